// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared state encoding, LED bar constants and value-to-LED decode.
package led_pkg;

    localparam int LED_W       = 9;
    localparam int LED_MAX_VAL = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SW    = 2'b01,
        ST_UART  = 2'b10,
        ST_CHASE = 2'b11
    } state_e;

    // Values 1..LED_MAX_VAL light bit v-1; zero and out-of-range values blank the bar.
    function automatic logic [LED_W-1:0] led_decode(input logic [3:0] v);
        logic [LED_W-1:0] r;
        r = '0;
        for (int i = 0; i < LED_MAX_VAL; i++) begin
            if (v == 4'(i + 1)) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/led_display_scheduler_if.sv
// rtl/led_display_scheduler_if.sv - request/data inputs and LED/grant outputs of the scheduler.
interface led_display_scheduler_if;
    import led_pkg::*;

    logic             req_sw;
    logic [3:0]       sw_data;
    logic             req_uart;
    logic [3:0]       uart_data;
    logic             uart_release;
    logic             chase_en;
    logic [LED_W-1:0] o_led_data;
    logic [1:0]       o_grant;
    logic             o_busy;

    modport master (
        output req_sw, sw_data, req_uart, uart_data, uart_release, chase_en,
        input  o_led_data, o_grant, o_busy
    );

    modport slave (
        input  req_sw, sw_data, req_uart, uart_data, uart_release, chase_en,
        output o_led_data, o_grant, o_busy
    );

endinterface

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - free-running divider emitting a one-cycle tick every TICK_DIV clocks.
module led_tick_gen #(
    parameter int TICK_DIV = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = (cnt_q == CNT_W'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_display_scheduler.sv
// rtl/led_display_scheduler.sv - arbitrates the LED bar between UART, switch and chase sources.
module led_display_scheduler #(
    parameter int TICK_DIV   = 10_000_000,
    parameter int HOLD_TICKS = 20,
    parameter int LED_W      = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    led_display_scheduler_if.slave   bus
);
    import led_pkg::*;

    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    state_e           state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [3:0]       uart_q, uart_d;
    logic [3:0]       chase_q, chase_d;
    logic [LED_W-1:0] led_q, led_d;
    logic             tick;
    logic             hold_done;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick)
    );

    // The hold expires on the tick that would bring the counter up to HOLD_TICKS.
    assign hold_done = tick && (hold_q == HOLD_W'(HOLD_TICKS - 1));

    always_comb begin
        state_d = state_q;
        if (bus.req_uart) begin
            state_d = ST_UART;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_sw) begin
                        state_d = ST_SW;
                    end else if (bus.chase_en) begin
                        state_d = ST_CHASE;
                    end
                end
                ST_SW: begin
                    if (!bus.req_sw) begin
                        state_d = bus.chase_en ? ST_CHASE : ST_IDLE;
                    end
                end
                ST_UART: begin
                    if (bus.uart_release || hold_done) begin
                        if (bus.req_sw) begin
                            state_d = ST_SW;
                        end else if (bus.chase_en) begin
                            state_d = ST_CHASE;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_CHASE: begin
                    if (bus.req_sw) begin
                        state_d = ST_SW;
                    end else if (!bus.chase_en) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        uart_d  = uart_q;
        hold_d  = hold_q;
        chase_d = chase_q;
        led_d   = '0;

        if (bus.req_uart) begin
            uart_d = bus.uart_data;
            hold_d = '0;
        end else if (state_q == ST_UART && tick) begin
            hold_d = hold_q + 1'b1;
        end

        // Every fresh entry into CHASE restarts the animation at the first LED.
        if (state_d == ST_CHASE && state_q != ST_CHASE) begin
            chase_d = 4'd1;
        end else if (state_q == ST_CHASE && tick) begin
            chase_d = (chase_q == 4'(LED_MAX_VAL)) ? 4'd1 : chase_q + 4'd1;
        end

        case (state_q)
            ST_SW:    led_d = led_decode(bus.sw_data);
            ST_UART:  led_d = led_decode(uart_q);
            ST_CHASE: led_d = led_decode(chase_q);
            default:  led_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            uart_q  <= '0;
            chase_q <= 4'd1;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            uart_q  <= uart_d;
            chase_q <= chase_d;
            led_q   <= led_d;
        end
    end

    assign bus.o_led_data = led_q;
    assign bus.o_grant    = state_q;
    assign bus.o_busy     = (state_q != ST_IDLE);

endmodule
